// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator controller: FSM states, travel direction
// and the floor names inherited from the 3-floor design.
package elevator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_UP    = 3'd1,
    ST_DOWN  = 3'd2,
    ST_DOOR  = 3'd3,
    ST_EMERG = 3'd4
  } state_t;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  localparam int FLOOR_1ST = 0;
  localparam int FLOOR_2ND = 1;
  localparam int FLOOR_3RD = 2;

endpackage

// File: rtl/call_scanner.sv
// Combinational summary of the pending-call vector relative to one floor:
// any call above it, any call below it, and a call at that floor itself.
module call_scanner
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 3,
  parameter int FLOOR_W    = 2
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    current_floor,
  output logic                  any_above,
  output logic                  any_below,
  output logic                  here
);

  // NOTE: every output gets a default before the loop, so no path through
  // this block leaves one unassigned and no latch is inferred.
  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    here      = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (FLOOR_W'(i) > current_floor) any_above = any_above | pending[i];
      if (FLOOR_W'(i) < current_floor) any_below = any_below | pending[i];
      if (FLOOR_W'(i) == current_floor) here = pending[i];
    end
  end

endmodule

// File: rtl/elevator_controller.sv
// NUM_FLOORS elevator controller: latched calls, SCAN direction policy, timed
// door with weight hold and an SOS emergency state. All outputs are registered.
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = 3,
  parameter int FLOOR_W      = 2,
  parameter int TRAVEL_TICKS = 3,
  parameter int DOOR_TICKS   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic [NUM_FLOORS-1:0] call_button,
  input  logic                  sos_button,
  input  logic                  weight_sensor,
  output logic [NUM_FLOORS-1:0] floor_led,
  output logic [NUM_FLOORS-1:0] call_led,
  output logic                  up_led,
  output logic                  down_led,
  output logic                  door_led,
  output logic                  weight_led,
  output logic                  sos_led,
  output logic                  emergency_led,
  output logic [FLOOR_W-1:0]    current_floor
);

  localparam int TW = $clog2(TRAVEL_TICKS + 1);
  localparam int DW = $clog2(DOOR_TICKS + 1);
  localparam logic [TW-1:0]         TRAVEL_LOAD = TW'(TRAVEL_TICKS);
  localparam logic [DW-1:0]         DOOR_LOAD   = DW'(DOOR_TICKS);
  localparam logic [NUM_FLOORS-1:0] ONE         = NUM_FLOORS'(1);

  state_t                  state, state_nxt;
  dir_t                    dir, dir_nxt;
  logic [FLOOR_W-1:0]      floor_nxt, arrive_floor;
  logic [NUM_FLOORS-1:0]   pending, pending_nxt, floor_mask;
  logic [TW-1:0]           travel_cnt, travel_nxt;
  logic [DW-1:0]           door_cnt, door_nxt;
  logic                    door_led_nxt, door_btn;
  logic                    go_up, go_down;
  logic                    cur_above, cur_below, cur_here;
  logic                    arr_above, arr_below, arr_here;

  // Floor the car reaches when the running travel count expires.
  assign arrive_floor = (state == ST_DOWN) ? current_floor - FLOOR_W'(1)
                                           : current_floor + FLOOR_W'(1);

  call_scanner #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_scan_cur (
    .pending       (pending),
    .current_floor (current_floor),
    .any_above     (cur_above),
    .any_below     (cur_below),
    .here          (cur_here)
  );

  call_scanner #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_scan_arr (
    .pending       (pending),
    .current_floor (arrive_floor),
    .any_above     (arr_above),
    .any_below     (arr_below),
    .here          (arr_here)
  );

  always_comb begin
    state_nxt   = state;
    dir_nxt     = dir;
    floor_nxt   = current_floor;
    travel_nxt  = travel_cnt;
    door_nxt    = door_cnt;
    floor_mask  = ONE << current_floor;
    door_btn    = (call_button & floor_mask) != '0;
    // SCAN: keep the current direction while it has work, else reverse.
    go_up       = cur_above && (dir == DIR_UP || !cur_below);
    go_down     = cur_below && (dir == DIR_DOWN || !cur_above);

    // A press at the open door's own floor re-opens the door instead of latching.
    unique case (state)
      ST_DOOR:  pending_nxt = pending | (call_button & ~floor_mask);
      ST_EMERG: pending_nxt = pending;
      default:  pending_nxt = pending | call_button;
    endcase

    case (state)
      ST_IDLE: begin
        if (tick) begin
          if (cur_here) begin
            pending_nxt = pending_nxt & ~floor_mask;
            door_nxt    = DOOR_LOAD;
            state_nxt   = ST_DOOR;
          end else if (!weight_sensor && go_up) begin
            travel_nxt = TRAVEL_LOAD;
            dir_nxt    = DIR_UP;
            state_nxt  = ST_UP;
          end else if (!weight_sensor && go_down) begin
            travel_nxt = TRAVEL_LOAD;
            dir_nxt    = DIR_DOWN;
            state_nxt  = ST_DOWN;
          end
        end
      end
      ST_UP, ST_DOWN: begin
        if (tick) begin
          travel_nxt = travel_cnt - TW'(1);
          if (travel_nxt == '0) begin
            floor_nxt = arrive_floor;
            if (arr_here) begin
              pending_nxt = pending_nxt & ~(ONE << arrive_floor);
              door_nxt    = DOOR_LOAD;
              state_nxt   = ST_DOOR;
            end else if ((state == ST_UP) ? arr_above : arr_below) begin
              travel_nxt = TRAVEL_LOAD;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
      end
      ST_DOOR: begin
        if (weight_sensor || door_btn) begin
          door_nxt = DOOR_LOAD;
        end else if (tick) begin
          door_nxt = door_cnt - DW'(1);
          if (door_nxt == '0) state_nxt = ST_IDLE;
        end
      end
      ST_EMERG: begin
        if (tick && !sos_button) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // SOS overrides whatever the tick or a call would have done this cycle.
    if (sos_button) begin
      state_nxt   = ST_EMERG;
      dir_nxt     = dir;
      floor_nxt   = current_floor;
      pending_nxt = '0;
      travel_nxt  = '0;
      door_nxt    = door_cnt;
    end

    door_led_nxt = (state_nxt == ST_DOOR) ||
                   (state_nxt == ST_EMERG &&
                    (state == ST_DOOR || (state == ST_EMERG && door_led)));
  end

  // NOTE: non-blocking assignments make every register update from the values
  // held before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      dir           <= DIR_UP;
      current_floor <= '0;
      pending       <= '0;
      travel_cnt    <= '0;
      door_cnt      <= '0;
      floor_led     <= ONE;
      call_led      <= '0;
      up_led        <= 1'b0;
      down_led      <= 1'b0;
      door_led      <= 1'b0;
      weight_led    <= 1'b0;
      sos_led       <= 1'b0;
      emergency_led <= 1'b0;
    end else begin
      state         <= state_nxt;
      dir           <= dir_nxt;
      current_floor <= floor_nxt;
      pending       <= pending_nxt;
      travel_cnt    <= travel_nxt;
      door_cnt      <= door_nxt;
      floor_led     <= ONE << floor_nxt;
      call_led      <= pending_nxt;
      up_led        <= (state_nxt == ST_UP);
      down_led      <= (state_nxt == ST_DOWN);
      door_led      <= door_led_nxt;
      weight_led    <= weight_sensor;
      sos_led       <= (state_nxt == ST_EMERG);
      emergency_led <= (state_nxt == ST_EMERG);
    end
  end

endmodule

// File: tb/tb_elevator_controller.sv
// Scoreboard bench: stimulus queues the expected output snapshot and tick stamp
// of every output change; monitors compare each change the DUTs present.
module tb_elevator_controller;

  typedef struct packed {
    logic [7:0] floor_led;
    logic [7:0] call_led;
    logic       up, down, door, weight, sos, emerg;
    logic [2:0] floor;
  } snap_t;

  typedef struct {
    snap_t s;
    int    t;
  } exp_t;

  localparam logic [5:0] F_NONE = 6'b000000;
  localparam logic [5:0] F_UP   = 6'b100000;
  localparam logic [5:0] F_DN   = 6'b010000;
  localparam logic [5:0] F_DOOR = 6'b001000;
  localparam logic [5:0] F_WT   = 6'b000100;
  localparam logic [5:0] F_EM   = 6'b000011;

  logic clk, rst_n;
  logic tick3, sos3, weight3;
  logic [2:0] call3;
  logic tick8, sos8, weight8;
  logic [7:0] call8;

  logic [2:0] floor_led3, call_led3;
  logic       up3, down3, door3, wled3, sled3, eled3;
  logic [1:0] cur3;
  logic [7:0] floor_led8, call_led8;
  logic       up8, down8, door8, wled8, sled8, eled8;
  logic [2:0] cur8;

  exp_t q3[$];
  exp_t q8[$];
  int   checks = 0;
  int   errors = 0;
  int   tcnt3 = 0, tcnt8 = 0;
  int   b3 = 0, b8 = 0;
  snap_t prev3 = 'x;
  snap_t prev8 = 'x;

  elevator_controller dut3 (
    .clk(clk), .rst_n(rst_n), .tick(tick3), .call_button(call3),
    .sos_button(sos3), .weight_sensor(weight3), .floor_led(floor_led3),
    .call_led(call_led3), .up_led(up3), .down_led(down3), .door_led(door3),
    .weight_led(wled3), .sos_led(sled3), .emergency_led(eled3),
    .current_floor(cur3)
  );

  elevator_controller #(
    .NUM_FLOORS(8), .FLOOR_W(3), .TRAVEL_TICKS(1), .DOOR_TICKS(1)
  ) dut8 (
    .clk(clk), .rst_n(rst_n), .tick(tick8), .call_button(call8),
    .sos_button(sos8), .weight_sensor(weight8), .floor_led(floor_led8),
    .call_led(call_led8), .up_led(up8), .down_led(down8), .door_led(door8),
    .weight_led(wled8), .sos_led(sled8), .emergency_led(eled8),
    .current_floor(cur8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tick3) tcnt3 <= tcnt3 + 1;
    if (tick8) tcnt8 <= tcnt8 + 1;
  end

  function automatic exp_t mk(int t, int fl, logic [7:0] calls, logic [5:0] bits);
    exp_t e;
    logic [7:0] one = 8'd1;
    e.s.floor_led = one << fl;
    e.s.call_led  = calls;
    {e.s.up, e.s.down, e.s.door, e.s.weight, e.s.sos, e.s.emerg} = bits;
    e.s.floor = 3'(fl);
    e.t = t;
    return e;
  endfunction

  task automatic e3(int dt, int fl, logic [7:0] calls, logic [5:0] bits);
    q3.push_back(mk(b3 + dt, fl, calls, bits));
  endtask

  task automatic e8(int dt, int fl, logic [7:0] calls, logic [5:0] bits);
    q8.push_back(mk(b8 + dt, fl, calls, bits));
  endtask

  task automatic check(string tag, snap_t got, int got_t, exp_t e);
    checks++;
    if (got !== e.s || got_t != e.t) begin
      errors++;
      $display("FAIL %s: got snap=%h at tick %0d, expected snap=%h at tick %0d",
               tag, got, got_t, e.s, e.t);
    end
  endtask

  task automatic unexpected(string tag, snap_t got, int got_t);
    checks++;
    errors++;
    $display("FAIL %s: unexpected output change snap=%h at tick %0d, expected none",
             tag, got, got_t);
  endtask

  always @(negedge clk) begin : mon3
    snap_t s;
    s = {{5'b0, floor_led3}, {5'b0, call_led3}, up3, down3, door3, wled3,
         sled3, eled3, {1'b0, cur3}};
    if (s !== prev3) begin
      prev3 = s;
      if (q3.size() == 0) unexpected("dut3", s, tcnt3);
      else check("dut3", s, tcnt3, q3.pop_front());
    end
  end

  always @(negedge clk) begin : mon8
    snap_t s;
    s = {floor_led8, call_led8, up8, down8, door8, wled8, sled8, eled8, cur8};
    if (s !== prev8) begin
      prev8 = s;
      if (q8.size() == 0) unexpected("dut8", s, tcnt8);
      else check("dut8", s, tcnt8, q8.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick3_n(int n, int gap);
    repeat (n) begin
      tick3 = 1'b1;
      cyc();
      tick3 = 1'b0;
      repeat (gap) cyc();
    end
  endtask

  task automatic tick8_n(int n, int gap);
    repeat (n) begin
      tick8 = 1'b1;
      cyc();
      tick8 = 1'b0;
      repeat (gap) cyc();
    end
  endtask

  task automatic press3(logic [2:0] v);
    call3 = v;
    cyc();
    call3 = '0;
    cyc();
  endtask

  task automatic press8(logic [7:0] v);
    call8 = v;
    cyc();
    call8 = '0;
    cyc();
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst_n = 1'b0; tick3 = 1'b0; call3 = '0; sos3 = 1'b0; weight3 = 1'b0;
    tick8 = 1'b0; call8 = '0; sos8 = 1'b0; weight8 = 1'b0;

    // Reset state of both instances.
    e3(0, 0, 8'h00, F_NONE);
    e8(0, 0, 8'h00, F_NONE);
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // Single call to the top floor: depart, pass floor 1, door for 2 ticks.
    b3 = tcnt3;
    e3(0, 0, 8'h04, F_NONE);
    e3(1, 0, 8'h04, F_UP);
    e3(4, 1, 8'h04, F_UP);
    e3(7, 2, 8'h00, F_DOOR);
    e3(9, 2, 8'h00, F_NONE);
    press3(3'b100);
    tick3_n(10, 2);

    // Reset asserted while moving down.
    b3 = tcnt3;
    e3(0, 2, 8'h01, F_NONE);
    e3(1, 2, 8'h01, F_DN);
    e3(2, 0, 8'h00, F_NONE);
    press3(3'b001);
    tick3_n(2, 2);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();

    // Calls at floors 1 and 2 with back-to-back ticks: stop at 1, then 2.
    b3 = tcnt3;
    e3(0, 0, 8'h06, F_NONE);
    e3(1, 0, 8'h06, F_UP);
    e3(4, 1, 8'h04, F_DOOR);
    e3(6, 1, 8'h04, F_NONE);
    e3(7, 1, 8'h04, F_UP);
    e3(10, 2, 8'h00, F_DOOR);
    e3(12, 2, 8'h00, F_NONE);
    press3(3'b110);
    tick3_n(12, 0);
    cyc();

    // Weight hold on the door, door reload by own-floor call, weight blocks departure.
    b3 = tcnt3;
    e3(0, 2, 8'h04, F_NONE);
    e3(1, 2, 8'h00, F_DOOR);
    e3(1, 2, 8'h00, F_DOOR | F_WT);
    e3(6, 2, 8'h00, F_DOOR);
    e3(9, 2, 8'h00, F_NONE);
    e3(9, 2, 8'h00, F_WT);
    e3(9, 2, 8'h01, F_WT);
    e3(12, 2, 8'h01, F_NONE);
    e3(13, 2, 8'h01, F_DN);
    e3(16, 1, 8'h01, F_DN);
    e3(19, 0, 8'h00, F_DOOR);
    e3(21, 0, 8'h00, F_NONE);
    press3(3'b100);
    tick3_n(1, 2);
    weight3 = 1'b1;
    cyc();
    tick3_n(5, 2);
    weight3 = 1'b0;
    cyc();
    tick3_n(1, 2);
    press3(3'b100);
    tick3_n(2, 2);
    weight3 = 1'b1;
    cyc();
    press3(3'b001);
    tick3_n(3, 2);
    weight3 = 1'b0;
    cyc();
    tick3_n(9, 2);

    // SOS mid-travel, calls ignored, full travel after release; SOS from open door.
    b3 = tcnt3;
    e3(0, 0, 8'h04, F_NONE);
    e3(1, 0, 8'h04, F_UP);
    e3(4, 1, 8'h04, F_UP);
    e3(5, 1, 8'h00, F_EM);
    e3(7, 1, 8'h00, F_NONE);
    e3(7, 1, 8'h04, F_NONE);
    e3(8, 1, 8'h04, F_UP);
    e3(11, 2, 8'h00, F_DOOR);
    e3(13, 2, 8'h00, F_NONE);
    e3(13, 2, 8'h04, F_NONE);
    e3(14, 2, 8'h00, F_DOOR);
    e3(15, 2, 8'h00, F_DOOR | F_EM);
    e3(16, 2, 8'h00, F_NONE);
    press3(3'b100);
    tick3_n(5, 2);
    sos3 = 1'b1;
    cyc();
    press3(3'b001);
    tick3_n(1, 2);
    sos3 = 1'b0;
    cyc();
    tick3_n(1, 2);
    press3(3'b100);
    tick3_n(6, 2);
    press3(3'b100);
    tick3_n(1, 2);
    sos3 = 1'b1;
    tick3 = 1'b1;
    cyc();
    tick3 = 1'b0;
    sos3 = 1'b0;
    cyc();
    tick3_n(1, 2);

    // Eight floors: go to 4 going up, then calls at 2 and 6 serve 6 first.
    b8 = tcnt8;
    e8(0, 0, 8'h10, F_NONE);
    e8(1, 0, 8'h10, F_UP);
    e8(2, 1, 8'h10, F_UP);
    e8(3, 2, 8'h10, F_UP);
    e8(4, 3, 8'h10, F_UP);
    e8(5, 4, 8'h00, F_DOOR);
    e8(6, 4, 8'h00, F_NONE);
    e8(6, 4, 8'h44, F_NONE);
    e8(7, 4, 8'h44, F_UP);
    e8(8, 5, 8'h44, F_UP);
    e8(9, 6, 8'h04, F_DOOR);
    e8(10, 6, 8'h04, F_NONE);
    e8(11, 6, 8'h04, F_DN);
    e8(12, 5, 8'h04, F_DN);
    e8(13, 4, 8'h04, F_DN);
    e8(14, 3, 8'h04, F_DN);
    e8(15, 2, 8'h00, F_DOOR);
    e8(16, 2, 8'h00, F_NONE);
    e8(16, 2, 8'h80, F_NONE);
    e8(17, 2, 8'h80, F_UP);
    e8(18, 3, 8'h80, F_UP);
    e8(19, 4, 8'h80, F_UP);
    e8(20, 5, 8'h80, F_UP);
    e8(21, 6, 8'h80, F_UP);
    e8(22, 7, 8'h00, F_DOOR);
    e8(23, 7, 8'h00, F_NONE);
    press8(8'h10);
    tick8_n(6, 1);
    press8(8'h44);
    tick8_n(10, 1);
    press8(8'h80);
    tick8_n(10, 1);

    for (int i = 0; i < 50 && (q3.size() != 0 || q8.size() != 0); i++) cyc();
    repeat (4) cyc();

    checks++;
    if (q3.size() != 0) begin
      errors++;
      $display("FAIL dut3 drain: %0d expected changes never seen, expected 0", q3.size());
    end
    checks++;
    if (q8.size() != 0) begin
      errors++;
      $display("FAIL dut8 drain: %0d expected changes never seen, expected 0", q8.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
